// File: rtl/countdown8_if.sv
// countdown8_if: load/control/status bundle for the countdown8 timer.
interface countdown8_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in;
  logic ld;
  logic start;
  logic stop;
  logic [WIDTH-1:0] out;
  logic busy;
  logic done;
  modport master (output in, ld, start, stop, input out, busy, done);
  modport slave (input in, ld, start, stop, output out, busy, done);
endinterface

// File: rtl/countdown8.sv
// countdown8: loadable down-counter/interval timer with a one-cycle done pulse.
// Define COUNTDOWN8_RELOAD_EN for periodic auto-reload from the last loaded value.
module countdown8 #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  countdown8_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt, done_val;
  logic rearm;
`ifdef COUNTDOWN8_RELOAD_EN
  logic [WIDTH-1:0] reload;
  always_ff @(posedge clk)
    if (!rst) reload <= '0;
    else if (bus.ld) reload <= bus.in;
  assign done_val = reload;
  assign rearm = reload != '0;
`else
  assign done_val = '0;
  assign rearm = 1'b0;
`endif
  // DONE treats start like IDLE does; otherwise it falls back to IDLE or re-arms RUN
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    if (bus.ld) begin
      state_nxt = IDLE;
      cnt_nxt = bus.in;
    end else if (bus.stop) begin
      state_nxt = IDLE;
    end else if (state == RUN) begin
      cnt_nxt = cnt == WIDTH'(1) ? done_val : cnt - WIDTH'(1);
      state_nxt = cnt == WIDTH'(1) ? DONE : RUN;
    end else if (bus.start) begin
      cnt_nxt = cnt == '0 ? done_val : cnt;
      state_nxt = cnt == '0 ? DONE : RUN;
    end else if (state == DONE) begin
      state_nxt = rearm ? RUN : IDLE;
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      bus.busy <= state_nxt == RUN;
      bus.done <= state_nxt == DONE;
    end
  assign bus.out = cnt;
endmodule
